// File: rtl/measurement_capture_counter_pkg.sv
// Shared build constants for the voltmeter deintegration counter and the
// configuration check used at elaboration.
package measurement_capture_counter_pkg;

    localparam int          DEFAULT_WIDTH     = 12;
    localparam logic [31:0] DEFAULT_MAX_COUNT = 32'd4095;
    localparam bit          DEFAULT_SATURATE  = 1'b1;

    // True when max_count is representable in a counter of the given width.
    function automatic bit max_count_fits(input int width, input logic [31:0] max_count);
        logic [32:0] limit;
        limit = 33'd1 << width;
        return ({1'b0, max_count} < limit);
    endfunction

endpackage

// File: rtl/measurement_result_reg.sv
// One-entry valid/ready holding register. Flags a capture request that
// arrives while the slot is still occupied and not being drained.
module measurement_result_reg #(
    parameter int DATA_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_req_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              drop_evt_o
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_slot_free;

    // Accepting the current entry frees the slot in the same cycle.
    assign w_slot_free = !r_valid || ready_i;
    assign drop_evt_o  = load_req_i && !w_slot_free;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (load_req_i && w_slot_free) begin
                r_data  <= data_i;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;

endmodule

// File: rtl/measurement_capture_counter.sv
// Deintegration pulse counter with saturate/wrap terminal behaviour, sticky
// overflow/drop flags and a one-entry result hand-off to conversion logic.
module measurement_capture_counter
    import measurement_capture_counter_pkg::*;
#(
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter logic [31:0] MAX_COUNT = DEFAULT_MAX_COUNT,
    parameter bit          SATURATE  = DEFAULT_SATURATE
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             count_en_i,
    input  logic             clear_i,
    input  logic             capture_i,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             overflow_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_ovf_o,
    output logic             result_valid_o,
    output logic             drop_o
);

    generate
        if (WIDTH < 2 || WIDTH > 32 || !max_count_fits(WIDTH, MAX_COUNT)) begin : g_bad_cfg
            $error("measurement_capture_counter: MAX_COUNT must fit in WIDTH bits, WIDTH 2..32");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic             r_drop;
    logic             w_tc;
    logic             w_drop_evt;
    logic [WIDTH:0]   w_result_payload;

    assign w_tc = (r_count == MAX_C);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (clear_i) begin
                r_count <= '0;
            end else if (count_en_i) begin
                if (w_tc) begin
                    r_count <= SATURATE ? MAX_C : '0;
                end else begin
                    r_count <= r_count + ONE_C;
                end
            end

            if (clear_i) begin
                r_overflow <= 1'b0;
            end else if (count_en_i && w_tc) begin
                r_overflow <= 1'b1;
            end

            // Clear wins over a simultaneous discarded capture.
            if (clear_i) begin
                r_drop <= 1'b0;
            end else if (w_drop_evt) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Capture always sees the pre-update count/overflow, so capture+clear
    // hands off the finished measurement while the counter restarts.
    measurement_result_reg #(
        .DATA_W (WIDTH + 1)
    ) u_result_reg (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_req_i (capture_i),
        .data_i     ({r_count, r_overflow}),
        .ready_i    (result_ready_i),
        .data_o     (w_result_payload),
        .valid_o    (result_valid_o),
        .drop_evt_o (w_drop_evt)
    );

    assign count_o      = r_count;
    assign tc_o         = w_tc;
    assign overflow_o   = r_overflow;
    assign drop_o       = r_drop;
    assign result_o     = w_result_payload[WIDTH:1];
    assign result_ovf_o = w_result_payload[0];

endmodule

// File: tb/tb_measurement_capture_counter.sv
// Scoreboard bench: three configurations share one stimulus stream; a
// behavioural model pushes expected outputs, a monitor pops and compares.
module tb_measurement_capture_counter;

    typedef struct packed {
        logic [31:0] count;
        logic        tc;
        logic        ovf;
        logic [31:0] res;
        logic        rovf;
        logic        rvalid;
        logic        drop;
    } mstate_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic cap = 1'b0;
    logic rdy = 1'b0;

    always #5 clk = ~clk;

    logic [11:0] d0_count, d0_res;
    logic [3:0]  d1_count, d1_res, d2_count, d2_res;
    logic        d0_tc, d0_ovf, d0_rovf, d0_rv, d0_drop;
    logic        d1_tc, d1_ovf, d1_rovf, d1_rv, d1_drop;
    logic        d2_tc, d2_ovf, d2_rovf, d2_rv, d2_drop;

    measurement_capture_counter #(.WIDTH(12), .MAX_COUNT(32'd4095), .SATURATE(1'b1)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .count_en_i(en), .clear_i(clr), .capture_i(cap),
        .result_ready_i(rdy), .count_o(d0_count), .tc_o(d0_tc), .overflow_o(d0_ovf),
        .result_o(d0_res), .result_ovf_o(d0_rovf), .result_valid_o(d0_rv), .drop_o(d0_drop));

    measurement_capture_counter #(.WIDTH(4), .MAX_COUNT(32'd9), .SATURATE(1'b1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .count_en_i(en), .clear_i(clr), .capture_i(cap),
        .result_ready_i(rdy), .count_o(d1_count), .tc_o(d1_tc), .overflow_o(d1_ovf),
        .result_o(d1_res), .result_ovf_o(d1_rovf), .result_valid_o(d1_rv), .drop_o(d1_drop));

    measurement_capture_counter #(.WIDTH(4), .MAX_COUNT(32'd9), .SATURATE(1'b0)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .count_en_i(en), .clear_i(clr), .capture_i(cap),
        .result_ready_i(rdy), .count_o(d2_count), .tc_o(d2_tc), .overflow_o(d2_ovf),
        .result_o(d2_res), .result_ovf_o(d2_rovf), .result_valid_o(d2_rv), .drop_o(d2_drop));

    int unsigned max_v [3] = '{4095, 9, 9};
    bit          sat_v [3] = '{1'b1, 1'b1, 1'b0};

    mstate_t model [3];
    mstate_t exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    bit stim_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    function automatic mstate_t mk(input logic [31:0] c, input logic t, input logic o,
                                   input logic [31:0] r, input logic ro, input logic rv,
                                   input logic d);
        mstate_t s;
        s = '{count: c, tc: t, ovf: o, res: r, rovf: ro, rvalid: rv, drop: d};
        return s;
    endfunction

    // Reference behaviour written directly from the operating rules.
    function automatic mstate_t model_next(input mstate_t s, input int unsigned mx, input bit sat,
                                           input bit r_n, input bit e, input bit c,
                                           input bit cp, input bit rd);
        mstate_t n;
        bit      at_max, slot_free;
        if (!r_n) begin
            n = '0;
            n.tc = (mx == 0);
            return n;
        end
        n = s;
        at_max    = (s.count == mx);
        slot_free = !s.rvalid || rd;
        if (cp && slot_free) begin
            n.res = s.count; n.rovf = s.ovf; n.rvalid = 1'b1;
        end else if (!cp && s.rvalid && rd) begin
            n.rvalid = 1'b0;
        end
        if (c)          n.count = 0;
        else if (e)     n.count = at_max ? (sat ? mx : 0) : s.count + 1;
        n.ovf  = c ? 1'b0 : (s.ovf | (e && at_max));
        n.drop = c ? 1'b0 : (s.drop | (cp && !slot_free));
        n.tc   = (n.count == mx);
        return n;
    endfunction

    task automatic step(input bit r_n, input bit e, input bit c, input bit cp, input bit rd);
        rst_n = r_n; en = e; clr = c; cap = cp; rdy = rd;
        for (int i = 0; i < 3; i++) begin
            model[i] = model_next(model[i], max_v[i], sat_v[i], r_n, e, c, cp, rd);
            exp_q.push_back(model[i]);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic cmp(input int idx, input mstate_t a, input mstate_t e);
        chk($sformatf("d%0d_count", idx),  a.count,  e.count);
        chk($sformatf("d%0d_tc", idx),     a.tc,     e.tc);
        chk($sformatf("d%0d_ovf", idx),    a.ovf,    e.ovf);
        chk($sformatf("d%0d_rvalid", idx), a.rvalid, e.rvalid);
        chk($sformatf("d%0d_drop", idx),   a.drop,   e.drop);
        chk($sformatf("d%0d_result", idx), a.res,    e.res);
        chk($sformatf("d%0d_res_ovf", idx), a.rovf,  e.rovf);
    endtask

    // Monitor: one snapshot per configuration after every clock edge.
    initial begin
        mstate_t a [3];
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() >= 3) begin
                a[0] = mk(32'(d0_count), d0_tc, d0_ovf, 32'(d0_res), d0_rovf, d0_rv, d0_drop);
                a[1] = mk(32'(d1_count), d1_tc, d1_ovf, 32'(d1_res), d1_rovf, d1_rv, d1_drop);
                a[2] = mk(32'(d2_count), d2_tc, d2_ovf, 32'(d2_res), d2_rovf, d2_rv, d2_drop);
                for (int i = 0; i < 3; i++) cmp(i, a[i], exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) model[i] = '0;
        repeat (2) step(0, 0, 0, 0, 0);
        chk("reset_count", 32'(d0_count), 0);
        chk("reset_valid", 32'(d0_rv), 0);

        repeat (10) step(1, 1, 0, 0, 0);
        chk("plan_cnt10", 32'(d0_count), 10);
        chk("plan_cnt10_tc", 32'(d0_tc), 0);
        repeat (2) step(1, 1, 0, 0, 0);
        chk("plan_sat_cnt", 32'(d1_count), 9);
        chk("plan_sat_ovf", 32'(d1_ovf), 1);
        chk("plan_wrap_cnt", 32'(d2_count), 2);
        chk("plan_wrap_ovf", 32'(d2_ovf), 1);
        step(1, 0, 1, 0, 0);
        chk("plan_clear_ovf", 32'(d1_ovf), 0);

        repeat (37) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        chk("plan_capclr_res", 32'(d0_res), 37);
        chk("plan_capclr_cnt", 32'(d0_count), 0);
        step(1, 1, 0, 0, 0);
        chk("plan_restart_cnt", 32'(d0_count), 1);
        step(1, 0, 0, 0, 1);

        step(1, 0, 1, 0, 0);
        repeat (5) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("plan_drop_res", 32'(d0_res), 5);
        chk("plan_drop_flag", 32'(d0_drop), 1);
        repeat (4) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1);
        chk("plan_b2b_res", 32'(d0_res), 12);
        chk("plan_b2b_valid", 32'(d0_rv), 1);

        step(1, 0, 1, 0, 0);
        repeat (20) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("plan_rst_valid", 32'(d0_rv), 0);
        chk("plan_rst_res", 32'(d0_res), 0);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(99) != 0, $urandom_range(3) != 0, $urandom_range(19) == 0,
                 $urandom_range(6) == 0, $urandom_range(1) == 1);
        end

        stim_done = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
